matrix_frame_scheduler: RTL and testbench

MATRIX_FRAME_SCHEDULER -- requirements
Module: matrix_frame_scheduler

---
 rtl/matrix_pkg.sv | 27 ++
 rtl/matrix_write_arbiter.sv | 41 ++++
 rtl/matrix_frame_scheduler.sv | 141 ++++++++++++++
 tb/tb_matrix_frame_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and types for the dual-matrix frame scheduler.
package matrix_pkg;

  localparam int MATRIX_ROWS         = 8;
  localparam int MATRIX_COLS         = 8;
  localparam int ROW_W               = $clog2(MATRIX_ROWS);
  localparam int REFRESH_DIV_DEFAULT = 2500;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  typedef logic [MATRIX_COLS-1:0] col_t;
  typedef logic [MATRIX_ROWS-1:0] row_sel_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  // Active-low row select: row r pulls bit (MATRIX_ROWS-1-r) low.
  function automatic row_sel_t row_select(input logic [ROW_W-1:0] row);
    row_sel_t sel;
    sel = {1'b1, {(MATRIX_ROWS-1){1'b0}}} >> row;
    return ~sel;
  endfunction

endpackage

// File: rtl/matrix_write_arbiter.sv
// Two-way round-robin arbiter for back-buffer writes; grants are combinational.
module matrix_write_arbiter
  import matrix_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  owner_e last_owner;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!hold) begin
      if (a_req && b_req) begin
        a_gnt = (last_owner == OWNER_B);
        b_gnt = (last_owner == OWNER_A);
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Only an accepted write moves the round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= OWNER_B;
    end else if (a_gnt) begin
      last_owner <= OWNER_A;
    end else if (b_gnt) begin
      last_owner <= OWNER_B;
    end
  end

endmodule

// File: rtl/matrix_frame_scheduler.sv
// Double-buffered two-matrix LED scheduler: row refresh divider, tear-free swap
// at the frame boundary, and arbitrated back-buffer writes from two requesters.
module matrix_frame_scheduler
  import matrix_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic       a_side,
  input  logic [2:0] a_row,
  input  logic [7:0] a_data,
  output logic       a_gnt,
  input  logic       b_req,
  input  logic       b_side,
  input  logic [2:0] b_row,
  input  logic [7:0] b_data,
  output logic       b_gnt,
  input  logic       swap_req,
  input  logic       blank,
  output logic       swap_pending,
  output logic       swap_done,
  output logic       frame_start,
  output logic [7:0] dot_matrix_row,
  output logic [7:0] dot_matrix_left_col,
  output logic [7:0] dot_matrix_right_col
);

  localparam int CNT_W = (REFRESH_DIV < 1) ? 1 : $clog2(REFRESH_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MATRIX_ROWS - 1);

  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] row_count;
  col_t             front_buf [2][MATRIX_ROWS];
  col_t             back_buf  [2][MATRIX_ROWS];

  logic             expiry;
  logic             boundary;
  logic             do_swap;
  logic             wr_en;
  logic             wr_side;
  logic [ROW_W-1:0] wr_row;
  col_t             wr_data;

  assign expiry   = (cnt == CNT_LAST);
  assign boundary = expiry && (row_count == LAST_ROW);
  assign do_swap  = boundary && swap_pending;

  matrix_write_arbiter u_arbiter (
    .clk   (clk),
    .reset (reset),
    .hold  (swap_pending),
    .a_req (a_req),
    .b_req (b_req),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  always_comb begin
    wr_en   = a_gnt | b_gnt;
    wr_side = b_side;
    wr_row  = b_row;
    wr_data = b_data;
    if (a_gnt) begin
      wr_side = a_side;
      wr_row  = a_row;
      wr_data = a_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt                  <= '0;
      row_count            <= '0;
      dot_matrix_row       <= '1;
      dot_matrix_left_col  <= '0;
      dot_matrix_right_col <= '0;
      frame_start          <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (expiry) begin
        cnt         <= '0;
        row_count   <= row_count + 1'b1;
        frame_start <= (row_count == '0);
        // Blanking only masks the drivers; the scan position keeps moving.
        if (blank) begin
          dot_matrix_row       <= '1;
          dot_matrix_left_col  <= '0;
          dot_matrix_right_col <= '0;
        end else begin
          dot_matrix_row       <= row_select(row_count);
          dot_matrix_left_col  <= front_buf[SIDE_LEFT][row_count];
          dot_matrix_right_col <= front_buf[SIDE_RIGHT][row_count];
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A request landing on the boundary edge itself sees pending=0 and waits a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) begin
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Grants are held off while a swap is pending, so copy and write never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        for (int r = 0; r < MATRIX_ROWS; r++) begin
          front_buf[s][r] <= '0;
          back_buf[s][r]  <= '0;
        end
      end
    end else begin
      if (do_swap) begin
        for (int s = 0; s < 2; s++) begin
          for (int r = 0; r < MATRIX_ROWS; r++) begin
            front_buf[s][r] <= back_buf[s][r];
          end
        end
      end
      if (wr_en) begin
        back_buf[wr_side][wr_row] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Bench for matrix_frame_scheduler: per-cycle reference model plus directed scenarios.
module tb_matrix_frame_scheduler;
  import matrix_pkg::*;

  localparam int DIV    = 3;
  localparam int PERIOD = DIV + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_req = 0, a_side = 0, b_req = 0, b_side = 0;
  logic [2:0] a_row = '0, b_row = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       swap_req = 0, blank = 0;
  logic       a_gnt, b_gnt, swap_pending, swap_done, frame_start;
  logic [7:0] dot_matrix_row, dot_matrix_left_col, dot_matrix_right_col;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_frame_scheduler #(.REFRESH_DIV(DIV)) dut (
    .clk                  (clk),
    .reset                (reset),
    .a_req                (a_req),
    .a_side               (a_side),
    .a_row                (a_row),
    .a_data               (a_data),
    .a_gnt                (a_gnt),
    .b_req                (b_req),
    .b_side               (b_side),
    .b_row                (b_row),
    .b_data               (b_data),
    .b_gnt                (b_gnt),
    .swap_req             (swap_req),
    .blank                (blank),
    .swap_pending         (swap_pending),
    .swap_done            (swap_done),
    .frame_start          (frame_start),
    .dot_matrix_row       (dot_matrix_row),
    .dot_matrix_left_col  (dot_matrix_left_col),
    .dot_matrix_right_col (dot_matrix_right_col)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges counted since reset release, buffers as plain arrays.
  logic [7:0] m_front [2][8];
  logic [7:0] m_back  [2][8];
  bit         m_pending, m_last_a;
  int         m_edges;
  logic [7:0] e_row, e_left, e_right;
  bit         e_fs, e_sd;

  function automatic void model_reset();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 8; r++) begin
        m_front[s][r] = '0;
        m_back[s][r]  = '0;
      end
    m_pending = 0; m_last_a = 0; m_edges = 0;
    e_row = 8'hFF; e_left = '0; e_right = '0; e_fs = 0; e_sd = 0;
  endfunction

  initial begin : compare
    bit ga, gb, swapped;
    int r;
    logic [7:0] sel;
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset) begin
        model_reset();
      end else begin
        check("row", dot_matrix_row, e_row);
        check("left_col", dot_matrix_left_col, e_left);
        check("right_col", dot_matrix_right_col, e_right);
        check("frame_start", frame_start, e_fs);
        check("swap_done", swap_done, e_sd);
        check("swap_pending", swap_pending, m_pending);
        ga = 0; gb = 0;
        if (!m_pending) begin
          if (a_req && b_req) begin
            ga = !m_last_a;
            gb = m_last_a;
          end else begin
            ga = a_req;
            gb = b_req;
          end
        end
        check("a_gnt", a_gnt, ga);
        check("b_gnt", b_gnt, gb);
        // Effects of the coming rising edge.
        m_edges++;
        e_fs = 0; e_sd = 0; swapped = 0;
        if (m_edges % PERIOD == 0) begin
          r = (m_edges / PERIOD - 1) % 8;
          sel = 8'h80 >> r;
          e_row   = blank ? 8'hFF : ~sel;
          e_left  = blank ? 8'h00 : m_front[0][r];
          e_right = blank ? 8'h00 : m_front[1][r];
          e_fs    = (r == 0);
          if (r == 7 && m_pending) begin
            m_front = m_back;
            swapped = 1;
            e_sd = 1;
          end
        end
        if (ga) begin m_back[a_side][a_row] = a_data; m_last_a = 1; end
        if (gb) begin m_back[b_side][b_row] = b_data; m_last_a = 0; end
        m_pending = swapped ? 0 : (m_pending | swap_req);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 0;
    a_req = 0; b_req = 0; swap_req = 0; blank = 0;
    tick(3);
    reset = 1;
  endtask

  task automatic wait_row(input logic [7:0] pattern, input int limit, input string name);
    int n = 0;
    while (dot_matrix_row !== pattern && n < limit) begin
      tick(1);
      n++;
    end
    check(name, dot_matrix_row, pattern);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int pulses, grants;
    logic [7:0] ga_seq;
    int ai, bi;

    // Idle refresh after reset.
    tick(2);
    do_reset();
    tick(4);
    check("hand_row0", dot_matrix_row, 8'h7F);
    check("hand_fs_row0", frame_start, 1'b1);
    tick(1);
    check("hand_fs_pulse", frame_start, 1'b0);
    tick(3);
    check("hand_row1", dot_matrix_row, 8'hBF);
    tick(24);
    check("hand_row7", dot_matrix_row, 8'hFE);
    tick(4);
    check("hand_wrap_row0", dot_matrix_row, 8'h7F);
    check("hand_wrap_fs", frame_start, 1'b1);
    tick(4);

    // Single write with swap requested in the same cycle.
    a_req = 1; a_side = SIDE_LEFT; a_row = 3'd2; a_data = 8'h3C; swap_req = 1;
    #1;
    check("hand_sole_a_gnt", a_gnt, 1'b1);
    tick(1);
    a_req = 0; swap_req = 0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (swap_done) pulses++;
    end
    check("hand_swap_done_pulses", pulses, 1);
    wait_row(8'hDF, 40, "wait_row2");
    check("hand_row2_left", dot_matrix_left_col, 8'h3C);
    check("hand_row2_right", dot_matrix_right_col, 8'h00);

    // Both requesters every cycle from reset: A,B,A,B...
    do_reset();
    tick(1);
    ai = 0; bi = 0;
    ga_seq = '0;
    for (int i = 0; i < 8; i++) begin
      a_req = 1; a_side = SIDE_RIGHT; a_row = 3'(ai); a_data = 8'hA0 + 8'(ai);
      b_req = 1; b_side = SIDE_LEFT;  b_row = 3'(4 + bi); b_data = 8'h50 + 8'(bi);
      #1;
      ga_seq[i] = a_gnt;
      tick(1);
      if (ga_seq[i]) ai++; else bi++;
    end
    a_req = 0; b_req = 0;
    check("hand_rr_order", ga_seq, 8'h55);
    swap_req = 1;
    tick(1);
    swap_req = 0;
    tick(40);
    wait_row(8'hF7, 40, "wait_row4");
    check("hand_rr_row4_left", dot_matrix_left_col, 8'h50);
    wait_row(8'h7F, 40, "wait_row0");
    check("hand_rr_row0_right", dot_matrix_right_col, 8'hA0);

    // Writes attempted while a swap is pending are held off.
    swap_req = 1;
    tick(1);
    swap_req = 0;
    a_req = 1; a_side = SIDE_LEFT;  a_row = 3'd1; a_data = 8'hFF;
    b_req = 1; b_side = SIDE_RIGHT; b_row = 3'd6; b_data = 8'hFF;
    grants = 0;
    pulses = 0;
    for (int i = 0; i < 80 && pulses == 0; i++) begin
      #1;
      if (a_gnt || b_gnt) grants++;
      tick(1);
      if (swap_done) pulses++;
    end
    a_req = 0; b_req = 0;
    check("hand_pending_grants", grants, 0);
    check("hand_pending_swap_seen", pulses, 1);

    // Blank for a full frame while a swap is pending.
    a_req = 1; a_side = SIDE_LEFT; a_row = 3'd1; a_data = 8'h81;
    swap_req = 1; blank = 1;
    tick(1);
    a_req = 0; swap_req = 0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (swap_done) pulses++;
    end
    check("hand_blank_swap", pulses, 1);
    check("hand_blank_row", dot_matrix_row, 8'hFF);
    check("hand_blank_left", dot_matrix_left_col, 8'h00);
    blank = 0;
    wait_row(8'hBF, 40, "wait_row1");
    check("hand_unblank_left", dot_matrix_left_col, 8'h81);

    // Reset mid-frame with a swap pending.
    wait_row(8'h7F, 40, "wait_frame");
    a_req = 1; a_side = SIDE_RIGHT; a_row = 3'd5; a_data = 8'h42; swap_req = 1;
    tick(1);
    a_req = 0; swap_req = 0;
    wait_row(8'hF7, 40, "wait_row4_pre_reset");
    check("hand_pending_before_reset", swap_pending, 1'b1);
    #2;
    reset = 0;
    #1;
    check("hand_rst_row", dot_matrix_row, 8'hFF);
    check("hand_rst_left", dot_matrix_left_col, 8'h00);
    check("hand_rst_right", dot_matrix_right_col, 8'h00);
    check("hand_rst_pending", swap_pending, 1'b0);
    tick(2);
    reset = 1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (swap_done) pulses++;
    end
    check("hand_no_swap_after_reset", pulses, 0);
    wait_row(8'hFB, 40, "wait_row5");
    check("hand_row5_right_cleared", dot_matrix_right_col, 8'h00);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
